matrix_decoder_controller: RTL

// - Control FSM for the matrix decoder, the inverse of the matrix encoder controller.
// - Walks all lanes of a stored encoded matrix: read lane -> load datapath reg -> inverse permute (unswap)
//   -> pass result through output mux -> write back. Owns the lane counter and produces read/write addresses.
// - Sits between the top-level start/done handshake and the decoder datapath (memory, lane reg, inverse-permute unit).

---
 rtl/matrix_decoder_controller.sv | 130 +++++++++++++
 1 files changed

// File: rtl/matrix_decoder_controller.sv
// rtl/matrix_decoder_controller.sv - lane-walking control FSM for the matrix decoder
module matrix_decoder_controller #(
   parameter int N_LANES = 64,
   parameter int CNT_W   = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             read_en,
   output logic [CNT_W-1:0] rd_addr,
   output logic             reg_en,
   output logic             inv_permute_en,
   output logic             mux_en,
   output logic             write_en,
   output logic [CNT_W-1:0] wr_addr,
   output logic             reg_rst,
   output logic             busy,
   output logic             done
);

   // Four bits leave spare encodings; any of them falls back to IDLE.
   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_BEGIN  = 4'd1,
      S_READ   = 4'd2,
      S_LOAD   = 4'd3,
      S_UNSWAP = 4'd4,
      S_UNLOAD = 4'd5,
      S_WRITE  = 4'd6,
      S_DONE   = 4'd7
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] lane_cnt;
   logic             armed;
   logic             last_lane;

   assign last_lane = (lane_cnt == CNT_W'(N_LANES - 1));
   assign rd_addr   = lane_cnt;
   assign wr_addr   = lane_cnt;

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Lane counter advances as each lane is written; natural wrap returns it to 0 for DONE.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lane_cnt <= '0;
      end else if (state == S_WRITE) begin
         lane_cnt <= lane_cnt + 1'b1;
      end
   end

   // Arm flag: a held start launches only one run; start must be seen low in IDLE to re-arm.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         armed <= 1'b1;
      end else if (state == S_IDLE) begin
         if (start && armed) begin
            armed <= 1'b0;
         end else if (!start) begin
            armed <= 1'b1;
         end
      end
   end

   // Next-state and per-state output decode.
   always_comb begin
      state_nxt      = S_IDLE;
      read_en        = 1'b0;
      reg_en         = 1'b0;
      inv_permute_en = 1'b0;
      mux_en         = 1'b0;
      write_en       = 1'b0;
      reg_rst        = 1'b0;
      busy           = 1'b0;
      done           = 1'b0;
      case (state)
         S_IDLE: begin
            reg_rst   = 1'b1;
            state_nxt = (start && armed) ? S_BEGIN : S_IDLE;
         end
         S_BEGIN: begin
            busy      = 1'b1;
            state_nxt = S_READ;
         end
         S_READ: begin
            read_en   = 1'b1;
            busy      = 1'b1;
            state_nxt = S_LOAD;
         end
         S_LOAD: begin
            reg_en    = 1'b1;
            busy      = 1'b1;
            state_nxt = S_UNSWAP;
         end
         S_UNSWAP: begin
            inv_permute_en = 1'b1;
            busy           = 1'b1;
            state_nxt      = S_UNLOAD;
         end
         S_UNLOAD: begin
            reg_en    = 1'b1;
            mux_en    = 1'b1;
            busy      = 1'b1;
            state_nxt = S_WRITE;
         end
         S_WRITE: begin
            write_en  = 1'b1;
            busy      = 1'b1;
            state_nxt = last_lane ? S_DONE : S_BEGIN;
         end
         S_DONE: begin
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

endmodule
